// File: rtl/bidir_sipo_receiver.sv
// Serial-in/parallel-out receiver for the bidirectional shift-register link.
// Reassembles WIDTH-bit words MSB-first or LSB-first into a one-entry handshake buffer.
module bidir_sipo_receiver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_in,
    input  logic             shift_dir,
    input  logic             frame_abort,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun,
    input  logic             ovr_clr
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             dir_q;

    logic             frame_start;
    logic             eff_dir;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_base;
    logic             complete;

    // An abort on the same cycle as a valid bit restarts the frame with that bit.
    always_comb begin
        frame_start = (state == IDLE) || frame_abort;
        eff_dir     = frame_start ? shift_dir : dir_q;
        base        = frame_start ? '0 : sr;
        cnt_base    = frame_start ? '0 : bit_count;
        shifted     = eff_dir ? {ser_in, base[WIDTH-1:1]} : {base[WIDTH-2:0], ser_in};
        complete    = ser_valid && (cnt_base == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            dir_q     <= 1'b0;
            bit_count <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ser_valid) begin
                dir_q <= eff_dir;
                if (complete) begin
                    sr        <= '0;
                    bit_count <= '0;
                    state     <= IDLE;
                end else begin
                    sr        <= shifted;
                    bit_count <= cnt_base + CNT_W'(1);
                    state     <= RECV;
                end
            end else if (frame_abort) begin
                sr        <= '0;
                bit_count <= '0;
                state     <= IDLE;
            end

            // A full buffer with no consumer drops the new word and flags it.
            if (complete && (!out_valid || out_ready)) begin
                data_out  <= shifted;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (complete && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state == RECV);

endmodule
